// File: rtl/modsq_pkg.sv
// Shared types for the modular squaring front end. These are the coefficient
// types, the controller state encoding and the coefficient-count derivation.
package modsq_pkg;

  localparam int unsigned DEF_MOD_LEN   = 1024;
  localparam int unsigned DEF_WORD_LEN  = 16;
  localparam int unsigned DEF_BIT_LEN   = 17;
  localparam int unsigned DEF_REDUNDANT = 2;

  function automatic int unsigned num_elements(input int unsigned mod_len,
                                               input int unsigned word_len,
                                               input int unsigned redundant);
    return mod_len / word_len + redundant;
  endfunction

  localparam int unsigned DEF_NUM_ELEMENTS =
    num_elements(DEF_MOD_LEN, DEF_WORD_LEN, DEF_REDUNDANT);

  typedef logic [DEF_BIT_LEN-1:0] coef_t;
  typedef coef_t [DEF_NUM_ELEMENTS-1:0] coef_arr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/modsq_io_pipe.sv
// Valid-tagged register pipeline of flat coefficient arrays with a
// synchronous clear.
module modsq_io_pipe #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned WIDTH  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int unsigned s = 0; s < STAGES; s++) r_data[s] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int unsigned s = 1; s < STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_data[s]  <= r_data[s-1];
      end
    end
  end

  assign o_valid = r_valid[STAGES-1];
  assign o_data  = r_data[STAGES-1];

endmodule

// File: rtl/modular_square_iter_ctrl.sv
// Front end for the modular squaring core. It splits the operand into coefficients,
// runs N chained squarings and returns the result through the output pipe.
module modular_square_iter_ctrl
  import modsq_pkg::*;
#(
  parameter int unsigned MOD_LEN            = 1024,
  parameter int unsigned WORD_LEN           = 16,
  parameter int unsigned BIT_LEN            = 17,
  parameter int unsigned REDUNDANT_ELEMENTS = 2,
  parameter int unsigned NUM_ELEMENTS       = num_elements(MOD_LEN, WORD_LEN, REDUNDANT_ELEMENTS),
  parameter int unsigned IO_STAGES          = 3,
  parameter int unsigned ITER_W             = 32,
  parameter int unsigned SQ_OUT_BITS        = NUM_ELEMENTS * 2 * WORD_LEN
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ITER_W-1:0]              iterations,
  input  logic [MOD_LEN-1:0]             sq_in,
  output logic                           busy,
  output logic [ITER_W-1:0]              iter_cnt,
  output logic [SQ_OUT_BITS-1:0]         sq_out,
  output logic                           valid,
  output logic                           core_start,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0] core_sq_in,
  input  logic [NUM_ELEMENTS*BIT_LEN-1:0] core_sq_out,
  input  logic                           core_valid
);

  localparam int unsigned NUM_WORDS = MOD_LEN / WORD_LEN;
  localparam int unsigned ARR_W     = NUM_ELEMENTS * BIT_LEN;

  state_t                   r_state, w_state_nxt;
  logic [ITER_W-1:0]        r_n, r_iter_cnt, w_iter_inc;
  logic [SQ_OUT_BITS-1:0]   r_sq_out, w_sq_load;
  logic                     r_valid;
  logic [ARR_W-1:0]         w_split, w_in_data, w_out_push_data, w_out_data;
  logic                     w_accept, w_in_vld, w_out_vld, w_out_push, w_core_start;

  always_comb begin
    w_split = '0;
    for (int unsigned j = 0; j < NUM_WORDS; j++)
      w_split[j*BIT_LEN +: WORD_LEN] = sq_in[j*WORD_LEN +: WORD_LEN];
  end

  assign w_accept   = start && (r_state == ST_IDLE);
  assign w_iter_inc = r_iter_cnt + ITER_W'(1);

  modsq_io_pipe #(.STAGES(IO_STAGES), .WIDTH(ARR_W)) u_in_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_accept),
    .i_data  (w_split),
    .o_valid (w_in_vld),
    .o_data  (w_in_data)
  );

  // N=0 feeds the input coefficients straight into the output pipe
  assign w_out_push_data = (r_state == ST_RUN) ? core_sq_out : w_in_data;

  modsq_io_pipe #(.STAGES(IO_STAGES), .WIDTH(ARR_W)) u_out_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_out_push),
    .i_data  (w_out_push_data),
    .o_valid (w_out_vld),
    .o_data  (w_out_data)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_core_start = 1'b0;
    w_out_push   = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_FILL;
      ST_FILL:
        if (w_in_vld) begin
          if (r_n != '0) begin
            w_core_start = 1'b1;
            w_state_nxt  = ST_RUN;
          end else begin
            w_out_push  = 1'b1;
            w_state_nxt = ST_DRAIN;
          end
        end
      ST_RUN:
        if (core_valid && (w_iter_inc == r_n)) begin
          w_out_push  = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      ST_DRAIN: if (w_out_vld) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sq_load = '0;
    for (int unsigned j = 0; j < NUM_ELEMENTS; j++)
      w_sq_load[j*2*WORD_LEN +: BIT_LEN] = w_out_data[j*BIT_LEN +: BIT_LEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_n        <= '0;
      r_iter_cnt <= '0;
      r_sq_out   <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      if (w_accept) begin
        r_n        <= iterations;
        r_iter_cnt <= '0;
      end
      if ((r_state == ST_RUN) && core_valid) r_iter_cnt <= w_iter_inc;
      if ((r_state == ST_DRAIN) && w_out_vld) begin
        r_valid  <= 1'b1;
        r_sq_out <= w_sq_load;
      end
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign iter_cnt   = r_iter_cnt;
  assign sq_out     = r_sq_out;
  assign valid      = r_valid;
  assign core_start = w_core_start;
  assign core_sq_in = w_in_data;

endmodule

// File: tb/tb_modular_square_iter_ctrl.sv
// Bench for modular_square_iter_ctrl with a behavioural squaring core
// (x^2 mod m, core_valid 8 cycles after start and after each iteration).
module tb_modular_square_iter_ctrl;

  localparam int unsigned MOD_LEN  = 64;
  localparam int unsigned WORD_LEN = 16;
  localparam int unsigned BIT_LEN  = 17;
  localparam int unsigned RED      = 2;
  localparam int unsigned NE       = MOD_LEN / WORD_LEN + RED;
  localparam int unsigned IO       = 3;
  localparam int unsigned ITER_W   = 32;
  localparam int unsigned SQB      = NE * 2 * WORD_LEN;
  localparam logic [63:0] MODULUS  = 64'hFFFF_FFFF_FFFF_FFC5;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [ITER_W-1:0]     iterations = '0;
  logic [MOD_LEN-1:0]    sq_in = '0;
  logic                  busy, valid, core_start;
  logic                  core_valid = 1'b0;
  logic [ITER_W-1:0]     iter_cnt;
  logic [SQB-1:0]        sq_out;
  logic [NE*BIT_LEN-1:0] core_sq_in, core_sq_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_core_start = 0;
  int n_valid = 0;
  logic [SQB-1:0] exp_q[$];

  modular_square_iter_ctrl #(
    .MOD_LEN(MOD_LEN), .WORD_LEN(WORD_LEN), .BIT_LEN(BIT_LEN),
    .REDUNDANT_ELEMENTS(RED), .NUM_ELEMENTS(NE), .IO_STAGES(IO),
    .ITER_W(ITER_W), .SQ_OUT_BITS(SQB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .iterations(iterations),
    .sq_in(sq_in), .busy(busy), .iter_cnt(iter_cnt), .sq_out(sq_out),
    .valid(valid), .core_start(core_start), .core_sq_in(core_sq_in),
    .core_sq_out(core_sq_out), .core_valid(core_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (core_start === 1'b1) n_core_start = n_core_start + 1;
    if (valid === 1'b1) n_valid = n_valid + 1;
  end

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    p = p % {64'd0, MODULUS};
    return p[63:0];
  endfunction

  function automatic logic [63:0] coefs_to_val(input logic [NE*BIT_LEN-1:0] c);
    logic [127:0] acc;
    acc = '0;
    for (int j = 0; j < NE; j++)
      acc = acc + ({111'd0, c[j*BIT_LEN +: BIT_LEN]} << (WORD_LEN * j));
    acc = acc % {64'd0, MODULUS};
    return acc[63:0];
  endfunction

  function automatic logic [SQB-1:0] expect_out(input logic [63:0] x, input int n);
    logic [63:0] v;
    logic [SQB-1:0] r;
    v = x;
    r = '0;
    for (int i = 0; i < n; i++) v = mulmod(v, v);
    for (int j = 0; j < 4; j++) r[j*32 +: 16] = v[j*16 +: 16];
    return r;
  endfunction

  // Behavioural core: keeps iterating on its own value until the next core_start
  logic [63:0] core_val = '0;
  int          core_cnt = 0;
  bit          core_active = 1'b0;

  always @(posedge clk) begin
    core_valid <= 1'b0;
    if (core_start === 1'b1) begin
      core_val    <= coefs_to_val(core_sq_in);
      core_cnt    <= 7;
      core_active <= 1'b1;
    end else if (core_active) begin
      if (core_cnt == 1) begin
        core_valid <= 1'b1;
        core_val   <= mulmod(core_val, core_val);
        core_cnt   <= 8;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  always_comb begin
    core_sq_out = '0;
    for (int j = 0; j < 4; j++) core_sq_out[j*BIT_LEN +: BIT_LEN] = {1'b0, core_val[j*16 +: 16]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (iter_cnt !== '0) begin errors++; $display("FAIL reset_iter_cnt: got %0d want 0", iter_cnt); end
    checks++; if (sq_out !== '0) begin errors++; $display("FAIL reset_sq_out: got %h want 0", sq_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b want 0", core_start); end
    checks++; if (core_sq_in !== '0) begin errors++; $display("FAIL reset_core_sq_in: got %h want 0", core_sq_in); end
  endtask

  task automatic test_single();
    logic [SQB-1:0] exp;
    bit seen, early;
    start = 1'b1; iterations = 1; sq_in = 64'h3;
    exp_q.push_back(expect_out(64'h3, 1));
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_c1: got %b want 1", busy); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL single_core_start_c1: got %b want 0", core_start); end
    tick();
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL single_core_start_c2: got %b want 0", core_start); end
    tick();
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL single_core_start_c3: got %b want 1", core_start); end
    checks++; if (core_sq_in[0 +: BIT_LEN] !== 17'd3) begin errors++; $display("FAIL single_coef0: got %h want 3", core_sq_in[0 +: BIT_LEN]); end
    checks++; if (core_sq_in[4*BIT_LEN +: 2*BIT_LEN] !== '0) begin errors++; $display("FAIL single_coef45: got %h want 0", core_sq_in[4*BIT_LEN +: 2*BIT_LEN]); end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (core_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL single_core_valid_timeout: got none want pulse"); end
    early = 1'b0;
    for (int i = 0; i < IO; i++) begin
      tick();
      if (valid !== 1'b0) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("FAIL single_valid_early: got pulse before t+4 want none"); end
    tick();
    exp = exp_q.pop_front();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid_t4: got %b want 1", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %b want 0", busy); end
    checks++; if (sq_out[31:0] !== 32'd9) begin errors++; $display("FAIL single_coef0_out: got %h want 9", sq_out[31:0]); end
    checks++; if (sq_out !== exp) begin errors++; $display("FAIL single_sq_out: got %h want %h", sq_out, exp); end
    checks++; if (iter_cnt !== 32'd1) begin errors++; $display("FAIL single_iter_cnt: got %0d want 1", iter_cnt); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid_pulse: got %b want 0", valid); end
    checks++; if (sq_out !== exp) begin errors++; $display("FAIL single_sq_out_hold: got %h want %h", sq_out, exp); end
  endtask

  task automatic test_multi();
    logic [SQB-1:0] exp;
    bit seen, step_ok;
    logic [ITER_W-1:0] last;
    n_core_start = 0; n_valid = 0;
    start = 1'b1; iterations = 5; sq_in = 64'h0123_4567_89AB_CDEF;
    exp_q.push_back(expect_out(64'h0123_4567_89AB_CDEF, 5));
    tick();
    start = 1'b0;
    last = '0; step_ok = 1'b1; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (iter_cnt !== last) begin
        if (iter_cnt !== last + 1) step_ok = 1'b0;
        last = iter_cnt;
      end
      if (valid === 1'b1) seen = 1'b1;
      else tick();
    end
    exp = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL multi_valid_timeout: got none want pulse"); end
    checks++; if (!step_ok || last !== 32'd5) begin errors++; $display("FAIL multi_iter_steps: got last=%0d ok=%0d want 5 ok=1", last, step_ok); end
    checks++; if (sq_out !== exp) begin errors++; $display("FAIL multi_sq_out: got %h want %h", sq_out, exp); end
    repeat (20) tick();
    checks++; if (n_core_start !== 1) begin errors++; $display("FAIL multi_core_starts: got %0d want 1", n_core_start); end
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL multi_valid_count: got %0d want 1", n_valid); end
    checks++; if (iter_cnt !== 32'd5) begin errors++; $display("FAIL multi_iter_sat: got %0d want 5", iter_cnt); end
  endtask

  task automatic test_passthrough();
    logic [SQB-1:0] exp;
    int first;
    n_core_start = 0;
    start = 1'b1; iterations = 0; sq_in = 64'h0004_0003_0002_0001;
    exp_q.push_back(expect_out(64'h0004_0003_0002_0001, 0));
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      start = 1'b0;
      if (valid === 1'b1 && first < 0) first = k;
    end
    exp = exp_q.pop_front();
    checks++; if (first !== 2*IO+1) begin errors++; $display("FAIL pass_valid_cycle: got %0d want %0d", first, 2*IO+1); end
    checks++; if (n_core_start !== 0) begin errors++; $display("FAIL pass_core_start: got %0d want 0", n_core_start); end
    checks++; if (sq_out !== exp) begin errors++; $display("FAIL pass_sq_out: got %h want %h", sq_out, exp); end
    checks++; if (sq_out[96 +: 32] !== 32'd4 || sq_out[128 +: 64] !== '0) begin errors++; $display("FAIL pass_coefs: got %h want 4 then zeros", sq_out[96 +: 96]); end
  endtask

  task automatic test_start_ignored();
    logic [SQB-1:0] exp;
    bit seen;
    n_core_start = 0; n_valid = 0;
    start = 1'b1; iterations = 3; sq_in = 64'h0000_BEEF_1234_5678;
    exp_q.push_back(expect_out(64'h0000_BEEF_1234_5678, 3));
    for (int k = 1; k <= 12; k++) begin
      tick();
      start = (k == 2 || k == 10);
      iterations = 1;
      sq_in = 64'h0000_0000_0000_0007;
    end
    start = 1'b0;
    wait_valid(100, seen);
    exp = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL ignore_valid_timeout: got none want pulse"); end
    checks++; if (sq_out !== exp) begin errors++; $display("FAIL ignore_sq_out: got %h want %h", sq_out, exp); end
    checks++; if (iter_cnt !== 32'd3) begin errors++; $display("FAIL ignore_iter_cnt: got %0d want 3", iter_cnt); end
    repeat (10) tick();
    checks++; if (n_valid !== 1 || n_core_start !== 1) begin errors++; $display("FAIL ignore_counts: got valid=%0d cs=%0d want 1 1", n_valid, n_core_start); end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    start = 1'b1; iterations = 4; sq_in = 64'h0000_0000_0000_0011;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (iter_cnt === 32'd2) seen = 1'b1;
      else tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_mid_reach2: got %0d want 2", iter_cnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({busy, valid, core_start} !== 3'b000 || iter_cnt !== '0 || sq_out !== '0 || core_sq_in !== '0)
      begin errors++; $display("FAIL rst_mid_outputs: got busy=%b valid=%b cs=%b cnt=%0d want all zero", busy, valid, core_start, iter_cnt); end
    n_valid = 0;
    repeat (30) tick();
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL rst_mid_no_valid: got %0d want 0", n_valid); end
    checks++; if (iter_cnt !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got cnt=%0d busy=%b want 0 0", iter_cnt, busy); end
  endtask

  task automatic test_back_to_back();
    logic [SQB-1:0] exp;
    bit seen;
    start = 1'b1; iterations = 1; sq_in = 64'h5;
    exp_q.push_back(expect_out(64'h5, 1));
    tick();
    start = 1'b0;
    wait_valid(100, seen);
    exp = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL b2b_first_timeout: got none want pulse"); end
    checks++; if (sq_out !== exp) begin errors++; $display("FAIL b2b_first_sq_out: got %h want %h", sq_out, exp); end
    start = 1'b1; iterations = 2; sq_in = 64'h7;
    exp_q.push_back(expect_out(64'h7, 2));
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
    tick();
    tick();
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL b2b_core_start: got %b want 1", core_start); end
    tick();
    wait_valid(100, seen);
    exp = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL b2b_second_timeout: got none want pulse"); end
    checks++; if (sq_out !== exp) begin errors++; $display("FAIL b2b_second_sq_out: got %h want %h", sq_out, exp); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_passthrough();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
